data_mem_resp: RTL
==================

Name: data_mem_resp

Overview:
- Data-memory responder: the target side of the MEM-stage memory interface (mem_en/mem_wen/mem_addr/mem_write_data in, mem_read_data out).
- Holds a word-organised RAM and services one request at a time with a programmable wait-state count.
- Signals completion with a one-cycle mem_ready pulse. The MEM stage stalls until mem_ready arrives.
- Flags misaligned and out-of-range accesses on mem_err.

Parameters:
- ADDR_WIDTH, 10, word-address bits; depth = 2**ADDR_WIDTH words.
- WAIT_CYCLES, 1, extra cycles between request capture and response; legal range 0..15.
- BASE_ADDR, 32'h0000_0000, byte address of word 0.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- mem_en  in  1  request valid.
- mem_wen  in  1  1 = write, 0 = read; sampled with mem_en.
- mem_addr  in  32  byte address.
- mem_write_data  in  32  write data.
- mem_byte_en  in  4  byte-lane write enables; bit i covers bits [8i+7:8i]; ignored for reads.
- mem_read_data  out  32  read data; valid when mem_ready=1.
- mem_ready  out  1  one-cycle response pulse.
- mem_err  out  1  error qualifier; valid with mem_ready.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - state=IDLE, wait counter=0.
  - mem_read_data=0, mem_ready=0, mem_err=0.
  - RAM contents are not reset.
  - Reset mid-transaction abandons the transaction; a pending write is not committed.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - mem_en=1 → capture addr, wen, wdata, byte_en.
  - Decode the error: err = (addr[1:0]!=0) or (addr-BASE_ADDR) ≥ 4*depth (unsigned; addr<BASE_ADDR is out of range).
  - Load counter=WAIT_CYCLES.
  - Go to WAIT if WAIT_CYCLES>0, else RESP.
- WAIT: decrement counter each cycle; at counter==1 go to RESP.
- RESP (one cycle):
  - Perform the access using the captured request.
  - Register outputs so that mem_ready=1 appears the cycle after RESP.
  - Return to IDLE.
- Latency: mem_ready asserts exactly WAIT_CYCLES+2 cycles after the capturing edge.
  - WAIT_CYCLES=0 → ready 2 edges after capture.
- Write:
  - err=0 → commit only the enabled byte lanes at word index (addr-BASE_ADDR)>>2.
  - mem_read_data=0 on the response.
  - byte_en=0000 is a legal no-op write that still responds.
- Read: err=0 → mem_read_data = RAM word (synchronous read in RESP).
- Error: no RAM update; mem_read_data=0; mem_err=1 for the mem_ready cycle.
- mem_ready, mem_err and mem_read_data are held at 0 in every cycle except the response cycle.
- mem_en while not IDLE is ignored, not queued. The initiator must hold mem_en until mem_ready.
  - If mem_en is still high in the ready cycle, the FSM is in IDLE, so the request is re-captured the following cycle. The initiator must drop mem_en in the ready cycle to avoid a duplicate access.
- Address arithmetic is 32-bit unsigned, with no wrap into range.

Optional Feature:
- DMEM_STATS_EN defined → adds three outputs:
  - rd_count[15:0]: counts responses with wen=0, err=0.
  - wr_count[15:0]: counts responses with wen=1, err=0.
  - err_count[7:0]: counts responses with err=1.
  - All counters saturate at their maximum, reset to 0 on reset_n, and increment in the mem_ready cycle.
- DMEM_STATS_EN not defined → no counter ports and no counter logic; behaviour otherwise identical.

Decomposition:
- Package dmem_pkg:
  - FSM state enum (IDLE, WAIT, RESP).
  - WORD_BYTES=4.
  - Width constants for the counter and stats fields.
  - Error-decode function.
- Sub-module dmem_array:
  - Depth 2**ADDR_WIDTH x 32.
  - Synchronous read.
  - Byte-enabled synchronous write.
  - Single port, no reset.

Test Plan:
- Write/read back:
  - WAIT_CYCLES=1: write addr 0x10, data 0xDEADBEEF, byte_en 1111; mem_ready at capture+3, err=0.
  - Then read 0x10 → mem_read_data=0xDEADBEEF, err=0.
- Byte lanes: from 0xDEADBEEF, write 0x11223344 with byte_en 0101; read → 0xDE22BE44.
- Misaligned: read 0x0000_0006 → ready with err=1, data=0. A prior write to 0x04 is unchanged on re-read.
- Out of range:
  - ADDR_WIDTH=10: write 0x0000_1000 → err=1, no RAM change.
  - Write 0x0000_0FFC → err=0.
- Latency/ignore:
  - WAIT_CYCLES=0: ready exactly 2 edges after capture.
  - WAIT_CYCLES=3: ready 5 edges after capture.
  - A second request pulsed during WAIT produces no extra ready.
- Reset mid-write: assert reset_n=0 during WAIT of a write to 0x20 → outputs 0 immediately (asynchronous). After release, read 0x20 returns the old value.
- With DMEM_STATS_EN: after the scenarios above → rd_count, wr_count and err_count match the scoreboard.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types, widths and address-error decode for the data-memory responder
package dmem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_e;
  localparam int WORD_BYTES = 4;
  localparam int CNT_W      = 4;
  localparam int RD_CNT_W   = 16;
  localparam int WR_CNT_W   = 16;
  localparam int ERR_CNT_W  = 8;
  // Misaligned, or offset from base beyond the array; offset is unsigned so addr<base is out of range
  function automatic logic addr_err(input logic [31:0] addr, input logic [31:0] base, input int aw);
    return (addr[1:0] != 2'b00) || ({1'b0, addr - base} >= (33'd4 << aw));
  endfunction
endpackage

// File: rtl/data_mem_resp_if.sv
// data_mem_resp_if: MEM-stage request/response bus between initiator and data-memory responder
interface data_mem_resp_if;
  import dmem_pkg::*;
  logic                    mem_en;
  logic                    mem_wen;
  logic [31:0]             mem_addr;
  logic [31:0]             mem_write_data;
  logic [WORD_BYTES-1:0]   mem_byte_en;
  logic [31:0]             mem_read_data;
  logic                    mem_ready;
  logic                    mem_err;
  modport master (output mem_en, mem_wen, mem_addr, mem_write_data, mem_byte_en,
                  input  mem_read_data, mem_ready, mem_err);
  modport slave  (input  mem_en, mem_wen, mem_addr, mem_write_data, mem_byte_en,
                  output mem_read_data, mem_ready, mem_err);
endinterface

// File: rtl/dmem_array.sv
// dmem_array: single-port word RAM with synchronous read and byte-lane write, no reset
module dmem_array import dmem_pkg::*; #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  en_i,
  input  logic                  we_i,
  input  logic [WORD_BYTES-1:0] be_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [31:0]           wdata_i,
  output logic [31:0]           rdata_o
);
  logic [31:0] ram_q [2**ADDR_WIDTH];
  logic [31:0] rdata_q;
  // One access per enabled cycle: enabled lanes written, old word read out
  always_ff @(posedge clk)
    if (en_i) begin
      for (int b = 0; b < WORD_BYTES; b++)
        if (we_i && be_i[b]) ram_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      rdata_q <= ram_q[addr_i];
    end
  assign rdata_o = rdata_q;
endmodule

// File: rtl/data_mem_resp.sv
// data_mem_resp: data-memory responder with wait states and error flag; DMEM_STATS_EN adds response counters
module data_mem_resp import dmem_pkg::*; #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  data_mem_resp_if.slave       mem
`ifdef DMEM_STATS_EN
  ,
  output logic [RD_CNT_W-1:0]  rd_count,
  output logic [WR_CNT_W-1:0]  wr_count,
  output logic [ERR_CNT_W-1:0] err_count
`endif
);
  dmem_state_e           state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  wen_q, req_err_q;
  logic [WORD_BYTES-1:0] be_q;
  logic [31:0]           wdata_q, rdata;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic                  ready_q, err_q, rd_ok_q;
  wire                   capture = (state_q == IDLE) && mem.mem_en;
  // Next state: IDLE captures, WAIT counts down the wait states, RESP lasts one cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: if (mem.mem_en) begin
        state_d = (WAIT_CYCLES > 0) ? WAIT : RESP;
        cnt_d   = CNT_W'(WAIT_CYCLES);
      end
      WAIT: begin
        cnt_d   = cnt_q - 1'b1;
        state_d = (cnt_q == CNT_W'(1)) ? RESP : WAIT;
      end
      default: state_d = IDLE;
    endcase
  end
  // Control state and response flags; ready/err/read-enable are pulses one cycle after RESP
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rd_ok_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= state_q == RESP;
      err_q   <= (state_q == RESP) && req_err_q;
      rd_ok_q <= (state_q == RESP) && !req_err_q && !wen_q;
    end
  // Request capture; contents only matter while a transaction is in flight
  always_ff @(posedge clk)
    if (capture) begin
      wen_q     <= mem.mem_wen;
      be_q      <= mem.mem_byte_en;
      wdata_q   <= mem.mem_write_data;
      idx_q     <= ADDR_WIDTH'((mem.mem_addr - BASE_ADDR) >> 2);
      req_err_q <= addr_err(mem.mem_addr, BASE_ADDR, int'(ADDR_WIDTH));
    end
  dmem_array #(.ADDR_WIDTH(ADDR_WIDTH)) u_array (
    .clk     (clk),
    .en_i    ((state_q == RESP) && !req_err_q),
    .we_i    (wen_q),
    .be_i    (be_q),
    .addr_i  (idx_q),
    .wdata_i (wdata_q),
    .rdata_o (rdata)
  );
  assign mem.mem_ready     = ready_q;
  assign mem.mem_err       = err_q;
  assign mem.mem_read_data = rd_ok_q ? rdata : '0;
`ifdef DMEM_STATS_EN
  logic [RD_CNT_W-1:0]  rd_q;
  logic [WR_CNT_W-1:0]  wr_q;
  logic [ERR_CNT_W-1:0] er_q;
  // Saturating response counters, bumped on the edge that raises mem_ready
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      rd_q <= '0;
      wr_q <= '0;
      er_q <= '0;
    end else if (state_q == RESP) begin
      if (req_err_q && !(&er_q)) er_q <= er_q + 1'b1;
      if (!req_err_q && !wen_q && !(&rd_q)) rd_q <= rd_q + 1'b1;
      if (!req_err_q && wen_q && !(&wr_q)) wr_q <= wr_q + 1'b1;
    end
  assign rd_count  = rd_q;
  assign wr_count  = wr_q;
  assign err_count = er_q;
`endif
endmodule
